bus_cycle_unit: RTL

- Parametrised bus interface unit between the CPU core and an external multiplexed address/data bus.
- Splits each core word access into BUS_W-wide beats and runs classic T1-T4 bus cycles per beat: ALE, RD_N/WR_N, DEN_N, DT_R, with READY-driven wait states.
- Adds two-cycle interrupt acknowledge and HOLD/HLDA bus arbitration.
- Sits between the core and the pin-level wrapper; the tri-state pad is resolved in the wrapper from ad_o/ad_oe/ad_i.

---
 rtl/biu_pkg.sv | 51 +++++
 rtl/bus_cycle_unit_if.sv | 44 ++++
 rtl/biu_lane_buf.sv | 59 +++++
 rtl/bus_cycle_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/biu_pkg.sv
// Shared types and reset values for the bus cycle unit: bus states, access kinds
// and the idle levels of every bus control output.
package biu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_HOLD
    } state_t;

    typedef enum logic [2:0] {
        MEM_RD,
        MEM_WR,
        IO_RD,
        IO_WR,
        INTA
    } kind_t;

    localparam logic RST_ALE    = 1'b0;
    localparam logic RST_RD_N   = 1'b1;
    localparam logic RST_WR_N   = 1'b1;
    localparam logic RST_DEN_N  = 1'b1;
    localparam logic RST_INTA_N = 1'b1;
    localparam logic RST_DT_R   = 1'b0;
    localparam logic RST_IOM    = 1'b0;

    function automatic kind_t kind_of(input logic we, input logic m_io);
        case ({m_io, we})
            2'b11:   return MEM_WR;
            2'b10:   return MEM_RD;
            2'b01:   return IO_WR;
            default: return IO_RD;
        endcase
    endfunction

    function automatic logic kind_is_wr(input kind_t k);
        return (k == MEM_WR) || (k == IO_WR);
    endfunction

    function automatic logic kind_is_rd(input kind_t k);
        return (k == MEM_RD) || (k == IO_RD);
    endfunction

    function automatic logic kind_is_mem(input kind_t k);
        return (k == MEM_RD) || (k == MEM_WR);
    endfunction

endpackage

// File: rtl/bus_cycle_unit_if.sv
// Core-side handshake and pin-level bus signals of the bus cycle unit.
// The master modport is the unit itself; slave is the core/pad environment.
interface bus_cycle_unit_if #(
    parameter int CORE_W = 16,
    parameter int BUS_W  = 8,
    parameter int ADDR_W = 20
);
    logic                    req;
    logic                    we;
    logic                    byte_op;
    logic                    m_io;
    logic [ADDR_W-1:0]       addr;
    logic [CORE_W-1:0]       wdata;
    logic [CORE_W-1:0]       rdata;
    logic                    ack;
    logic                    busy;
    logic                    inta_req;
    logic                    ready;
    logic                    hold;
    logic                    hlda;
    logic [ADDR_W-BUS_W-1:0] a_hi;
    logic [BUS_W-1:0]        ad_o;
    logic                    ad_oe;
    logic [BUS_W-1:0]        ad_i;
    logic                    ale;
    logic                    rd_n;
    logic                    wr_n;
    logic                    den_n;
    logic                    dt_r;
    logic                    inta_n;
    logic                    iom;

    modport master (
        input  req, we, byte_op, m_io, addr, wdata, inta_req, ready, hold, ad_i,
        output rdata, ack, busy, hlda, a_hi, ad_o, ad_oe,
               ale, rd_n, wr_n, den_n, dt_r, inta_n, iom
    );

    modport slave (
        output req, we, byte_op, m_io, addr, wdata, inta_req, ready, hold, ad_i,
        input  rdata, ack, busy, hlda, a_hi, ad_o, ad_oe,
               ale, rd_n, wr_n, den_n, dt_r, inta_n, iom
    );
endinterface

// File: rtl/biu_lane_buf.sv
// Beat counter plus write-lane select and read-lane assembly for splitting a
// CORE_W access into BUS_W beats.
module biu_lane_buf #(
    parameter int CORE_W = 16,
    parameter int BUS_W  = 8,
    parameter int CNT_W  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    input  logic              ld,
    input  logic [CORE_W-1:0] wdata,
    input  logic              cap,
    input  logic              zext,
    input  logic [BUS_W-1:0]  cap_data,
    output logic [CNT_W-1:0]  beat,
    output logic [BUS_W-1:0]  lane,
    output logic [CORE_W-1:0] rdata
);
    localparam int BEATS = CORE_W / BUS_W;

    logic [CNT_W-1:0]  beat_q;
    logic [CORE_W-1:0] wbuf_q;
    logic [CORE_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n)   beat_q <= '0;
        else if (clr) beat_q <= '0;
        else if (inc) beat_q <= beat_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (ld) wbuf_q <= wdata;
    end

    // Byte and vector captures replace the whole word so upper lanes read as zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (cap) begin
            if (zext) begin
                rdata_q <= CORE_W'(cap_data);
            end else begin
                for (int i = 0; i < BEATS; i++)
                    if (beat_q == CNT_W'(i)) rdata_q[i*BUS_W +: BUS_W] <= cap_data;
            end
        end
    end

    always_comb begin
        lane = '0;
        for (int i = 0; i < BEATS; i++)
            if (beat_q == CNT_W'(i)) lane = wbuf_q[i*BUS_W +: BUS_W];
    end

    assign beat  = beat_q;
    assign rdata = rdata_q;
endmodule

// File: rtl/bus_cycle_unit.sv
// T1-T4 multiplexed bus cycle engine with beat splitting, two-cycle interrupt
// acknowledge and HOLD/HLDA arbitration.
module bus_cycle_unit
    import biu_pkg::*;
#(
    parameter int CORE_W = 16,
    parameter int BUS_W  = 8,
    parameter int ADDR_W = 20
) (
    input logic              clk,
    input logic              rst_n,
    bus_cycle_unit_if.master bus
);
    localparam int BEATS = CORE_W / BUS_W;
    localparam int MAXB  = (BEATS > 2) ? BEATS : 2;
    localparam int CNT_W = $clog2(MAXB);
    localparam int STEP  = BUS_W / 8;

    state_t            state_q, state_d;
    kind_t             kind_q, kind_d;
    logic [CNT_W-1:0]  nbm1_q, nbm1_d;
    logic [ADDR_W-1:0] base_q;
    logic              byte_q;
    logic [CNT_W-1:0]  beat;
    logic [BUS_W-1:0]  lane;
    logic [BUS_W-1:0]  cap_data;
    logic [ADDR_W-1:0] beat_addr;
    logic              ld, inc, cap, last, dec, ack;
    logic              is_wr, is_rd, is_inta, is_mem;

    assign is_wr     = kind_is_wr(kind_q);
    assign is_rd     = kind_is_rd(kind_q);
    assign is_mem    = kind_is_mem(kind_q);
    assign is_inta   = (kind_q == INTA);
    assign last      = (beat == nbm1_q);
    assign beat_addr = base_q + ADDR_W'(beat) * ADDR_W'(STEP);
    assign cap_data  = is_inta ? BUS_W'(bus.ad_i[7:0]) : bus.ad_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            kind_q  <= MEM_RD;
            nbm1_q  <= '0;
            byte_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            nbm1_q  <= nbm1_d;
            if (ld) byte_q <= bus.byte_op && !(kind_d == INTA);
        end
    end

    // Address is captured once per access; later beats derive from it.
    always_ff @(posedge clk) begin
        if (ld) base_q <= (kind_d == INTA) ? '0 : bus.addr;
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        nbm1_d  = nbm1_q;
        ld      = 1'b0;
        inc     = 1'b0;
        cap     = 1'b0;
        ack     = 1'b0;
        dec     = 1'b0;
        case (state_q)
            S_IDLE: dec = 1'b1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (bus.ready) begin
                    state_d = S_T4;
                    cap     = is_rd || (is_inta && last);
                end
            end
            S_T4: begin
                if (!last) begin
                    inc     = 1'b1;
                    state_d = S_T1;
                end else begin
                    ack = 1'b1;
                    dec = 1'b1;
                end
            end
            S_HOLD:  if (!bus.hold) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Arbitration only at access boundaries: hold beats inta beats ordinary requests.
        if (dec) begin
            if (bus.hold) begin
                state_d = S_HOLD;
            end else if (bus.inta_req) begin
                state_d = S_T1;
                kind_d  = INTA;
                nbm1_d  = CNT_W'(1);
                ld      = 1'b1;
            end else if (bus.req) begin
                state_d = S_T1;
                kind_d  = kind_of(bus.we, bus.m_io);
                nbm1_d  = bus.byte_op ? '0 : CNT_W'(BEATS - 1);
                ld      = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    biu_lane_buf #(
        .CORE_W(CORE_W),
        .BUS_W (BUS_W),
        .CNT_W (CNT_W)
    ) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (ld),
        .inc     (inc),
        .ld      (ld),
        .wdata   (bus.wdata),
        .cap     (cap),
        .zext    (is_inta || byte_q),
        .cap_data(cap_data),
        .beat    (beat),
        .lane    (lane),
        .rdata   (bus.rdata)
    );

    logic                    ale, rd_n, wr_n, den_n, dt_r, inta_n, iom, ad_oe, hlda;
    logic [BUS_W-1:0]        ad_o;
    logic [ADDR_W-BUS_W-1:0] a_hi;

    always_comb begin
        ale    = RST_ALE;
        rd_n   = RST_RD_N;
        wr_n   = RST_WR_N;
        den_n  = RST_DEN_N;
        inta_n = RST_INTA_N;
        dt_r   = RST_DT_R;
        iom    = RST_IOM;
        ad_oe  = 1'b0;
        ad_o   = '0;
        a_hi   = '0;
        hlda   = 1'b0;
        if (state_q inside {S_T1, S_T2, S_T3, S_T4}) begin
            a_hi = beat_addr[ADDR_W-1:BUS_W];
            dt_r = is_wr;
            iom  = is_mem;
        end
        case (state_q)
            S_T1: begin
                ale = 1'b1;
                if (!is_inta) begin
                    ad_oe = 1'b1;
                    ad_o  = beat_addr[BUS_W-1:0];
                end
            end
            S_T2, S_T3: begin
                den_n  = 1'b0;
                rd_n   = !is_rd;
                wr_n   = !is_wr;
                inta_n = !is_inta;
                if (is_wr) begin
                    ad_oe = 1'b1;
                    ad_o  = lane;
                end
            end
            S_HOLD:  hlda = 1'b1;
            default: ;
        endcase
    end

    assign bus.ale    = ale;
    assign bus.rd_n   = rd_n;
    assign bus.wr_n   = wr_n;
    assign bus.den_n  = den_n;
    assign bus.dt_r   = dt_r;
    assign bus.inta_n = inta_n;
    assign bus.iom    = iom;
    assign bus.ad_oe  = ad_oe;
    assign bus.ad_o   = ad_o;
    assign bus.a_hi   = a_hi;
    assign bus.hlda   = hlda;
    assign bus.ack    = ack;
    assign bus.busy   = (state_q != S_IDLE);
endmodule
